// File: rtl/pm_motion_pkg.sv
// Shared types for the maze sprite motion controller: direction encoding and FSM states.
package pm_motion_pkg;

    typedef enum logic [1:0] {
        DIR_R = 2'd0,
        DIR_L = 2'd1,
        DIR_U = 2'd2,
        DIR_D = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_QRY_P = 2'd1,
        ST_QRY_C = 2'd2
    } mstate_t;

endpackage

// File: rtl/sprite_next_pos.sv
// Combinational one-step move with wrap-around at the play-field bounds.
module sprite_next_pos
    import pm_motion_pkg::*;
#(
    parameter int W     = 10,
    parameter int X_MIN = 150,
    parameter int X_MAX = 800,
    parameter int Y_MIN = 34,
    parameter int Y_MAX = 514,
    parameter int STEP  = 2
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  dir_t         dir_i,
    output logic [W-1:0] nx_o,
    output logic [W-1:0] ny_o
);

    localparam logic [W:0]   STEP_E = (W+1)'(STEP);
    localparam logic [W:0]   XMIN_E = (W+1)'(X_MIN);
    localparam logic [W:0]   XMAX_E = (W+1)'(X_MAX);
    localparam logic [W:0]   YMIN_E = (W+1)'(Y_MIN);
    localparam logic [W:0]   YMAX_E = (W+1)'(Y_MAX);
    localparam logic [W-1:0] STEP_N = W'(STEP);
    localparam logic [W-1:0] XMIN_N = W'(X_MIN);
    localparam logic [W-1:0] XMAX_N = W'(X_MAX);
    localparam logic [W-1:0] YMIN_N = W'(Y_MIN);
    localparam logic [W-1:0] YMAX_N = W'(Y_MAX);

    // One extra bit so the increment never wraps before the bound compare.
    logic [W:0] x_ext, y_ext, x_inc, y_inc;

    assign x_ext = {1'b0, x_i};
    assign y_ext = {1'b0, y_i};
    assign x_inc = x_ext + STEP_E;
    assign y_inc = y_ext + STEP_E;

    always_comb begin
        nx_o = x_i;
        ny_o = y_i;
        case (dir_i)
            DIR_R: nx_o = (x_inc > XMAX_E) ? XMIN_N : x_inc[W-1:0];
            DIR_L: nx_o = (x_ext < XMIN_E + STEP_E) ? XMAX_N : x_i - STEP_N;
            DIR_D: ny_o = (y_inc > YMAX_E) ? YMIN_N : y_inc[W-1:0];
            DIR_U: ny_o = (y_ext < YMIN_E + STEP_E) ? YMAX_N : y_i - STEP_N;
            default: ;
        endcase
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Maze sprite mover: buffers direction requests, probes a wall checker per tick, and
// produces sprite position plus raster fill/ROM addressing for the renderer.
//
//  state    | meaning
//  ---------|-----------------------------------------------------------
//  ST_IDLE  | waiting for tick; no probe outstanding
//  ST_QRY_P | probing the next position in the buffered (pending) direction
//  ST_QRY_C | probing the next position in the current direction
module sprite_motion_ctrl
    import pm_motion_pkg::*;
#(
    parameter int W       = 10,
    parameter int X_MIN   = 150,
    parameter int X_MAX   = 800,
    parameter int Y_MIN   = 34,
    parameter int Y_MAX   = 514,
    parameter int START_X = 450,
    parameter int START_Y = 250,
    parameter int STEP    = 2,
    parameter int SPR_W   = 30,
    parameter int SPR_H   = 30
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         up,
    input  logic         down,
    input  logic         left,
    input  logic         right,
    output logic         probe_req,
    output logic [W-1:0] probe_x,
    output logic [W-1:0] probe_y,
    input  logic         probe_ack,
    input  logic         probe_blocked,
    output logic [W-1:0] pos_x,
    output logic [W-1:0] pos_y,
    output logic [1:0]   dir,
    output logic         moving,
    output logic         face_left,
    input  logic [W-1:0] hCount,
    input  logic [W-1:0] vCount,
    output logic         spr_fill,
    output logic [W-1:0] spr_row,
    output logic [W-1:0] spr_col
);

    mstate_t      state_q, state_d;
    dir_t         dir_q, dir_d;
    dir_t         pend_dir_q, pend_dir_d;
    dir_t         qpend_q, qpend_d;
    logic         pend_v_q, pend_v_d;
    logic         moving_q, moving_d;
    logic         face_q, face_d;
    logic [W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;

    logic         btn_any, pend_clr;
    dir_t         btn_dir, probe_dir;
    logic [W-1:0] nx, ny;

    // The pending direction is latched at launch so a button change mid-query
    // cannot move the probe address while the wall checker is answering.
    assign probe_dir = (state_q == ST_QRY_P) ? qpend_q : dir_q;

    sprite_next_pos #(
        .W(W), .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX), .STEP(STEP)
    ) u_next (
        .x_i  (pos_x_q),
        .y_i  (pos_y_q),
        .dir_i(probe_dir),
        .nx_o (nx),
        .ny_o (ny)
    );

    assign btn_any = up | down | left | right;

    always_comb begin
        btn_dir = DIR_D;
        if (right)     btn_dir = DIR_R;
        else if (left) btn_dir = DIR_L;
        else if (up)   btn_dir = DIR_U;
    end

    assign pend_v_d   = btn_any ? 1'b1 : (pend_clr ? 1'b0 : pend_v_q);
    assign pend_dir_d = btn_any ? btn_dir : pend_dir_q;

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        qpend_d   = qpend_q;
        moving_d  = moving_q;
        face_d    = face_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        pend_clr  = 1'b0;
        probe_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    if (pend_v_q && (pend_dir_q != dir_q || !moving_q)) begin
                        state_d = ST_QRY_P;
                        qpend_d = pend_dir_q;
                    end else if (moving_q) begin
                        state_d = ST_QRY_C;
                    end
                end
            end
            ST_QRY_P: begin
                probe_req = 1'b1;
                if (probe_ack) begin
                    if (!probe_blocked) begin
                        pos_x_d  = nx;
                        pos_y_d  = ny;
                        dir_d    = qpend_q;
                        moving_d = 1'b1;
                        pend_clr = 1'b1;
                        if (qpend_q == DIR_L)      face_d = 1'b1;
                        else if (qpend_q == DIR_R) face_d = 1'b0;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d = moving_q ? ST_QRY_C : ST_IDLE;
                    end
                end
            end
            ST_QRY_C: begin
                probe_req = 1'b1;
                if (probe_ack) begin
                    if (!probe_blocked) begin
                        pos_x_d = nx;
                        pos_y_d = ny;
                        if (dir_q == DIR_L)      face_d = 1'b1;
                        else if (dir_q == DIR_R) face_d = 1'b0;
                    end else begin
                        moving_d = 1'b0;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            dir_q      <= DIR_R;
            qpend_q    <= DIR_R;
            pend_dir_q <= DIR_R;
            pend_v_q   <= 1'b0;
            moving_q   <= 1'b0;
            face_q     <= 1'b0;
            pos_x_q    <= W'(START_X);
            pos_y_q    <= W'(START_Y);
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            qpend_q    <= qpend_d;
            pend_dir_q <= pend_dir_d;
            pend_v_q   <= pend_v_d;
            moving_q   <= moving_d;
            face_q     <= face_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
        end
    end

    assign probe_x   = probe_req ? nx : '0;
    assign probe_y   = probe_req ? ny : '0;
    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign dir       = dir_q;
    assign moving    = moving_q;
    assign face_left = face_q;

    // Extended compares keep the box test correct near the top of the coordinate range.
    localparam logic [W:0]   ONE_E   = (W+1)'(1);
    localparam logic [W:0]   SPRW_E  = (W+1)'(SPR_W);
    localparam logic [W:0]   SPRH_E  = (W+1)'(SPR_H);
    localparam logic [W-1:0] ONE_N   = W'(1);
    localparam logic [W-1:0] SPRW1_N = W'(SPR_W - 1);

    logic [W:0]   hx, vy, px, py;
    logic [W-1:0] col_c;

    assign hx = {1'b0, hCount};
    assign vy = {1'b0, vCount};
    assign px = {1'b0, pos_x_q};
    assign py = {1'b0, pos_y_q};

    assign spr_fill = (hx >= px + ONE_E) && (hx <= px + SPRW_E) &&
                      (vy >= py) && (vy < py + SPRH_E);
    assign spr_row  = vCount - pos_y_q;
    assign col_c    = hCount - pos_x_q - ONE_N;
    assign spr_col  = face_q ? col_c : SPRW1_N - col_c;

endmodule

// File: doc/sprite_motion_ctrl.md
# sprite_motion_ctrl

- Parametrised successor to the single-sprite block controller.
- Moves one maze sprite (Pac-Man or a ghost) across a configurable play field, one `STEP` per `tick` strobe.
- Buffers the most recent direction request and applies it at the first legal opportunity, as arcade Pac-Man does.
- Checks each candidate position with an external wall checker over a req/ack handshake.
- Sits between the button debouncers/`legal_4` checker and the VGA renderer; supplies sprite position, fill and mirrored ROM addresses.

## Interface
- `W`, 10: coordinate width, in bits.
- `X_MIN`, 150 / `X_MAX`, 800: horizontal wrap bounds.
- `Y_MIN`, 34 / `Y_MAX`, 514: vertical wrap bounds.
- `START_X`, 450 / `START_Y`, 250: reset position.
- `STEP`, 2: pixels moved per committed tick.
- `SPR_W`, 30 / `SPR_H`, 30: sprite size, in pixels.
- `clk` in 1: the design's single clock. Ticks, the handshake and all state run on this clock; there is no slow clock.
- `rst` in 1: asynchronous, active-high reset.
- `tick` in 1: one-cycle movement strobe.
- `up`, `down`, `left`, `right` in 1 each: level direction requests.
- `probe_req` out 1: wall-query request.
- `probe_x`, `probe_y` out W each: candidate position for the wall query.
- `probe_ack` in 1: wall-query answer is valid.
- `probe_blocked` in 1: candidate position is a wall. Meaningful only when `probe_ack`=1.
- `pos_x`, `pos_y` out W each: current sprite position.
- `dir` out 2: current direction, encoded R=0, L=1, U=2, D=3.
- `moving` out 1: sprite has a current direction.
- `face_left` out 1: last committed horizontal direction was L.
- `hCount`, `vCount` in W each: current raster coordinates.
- `spr_fill` out 1: raster is inside the sprite box.
- `spr_row`, `spr_col` out W each: sprite ROM address.

## Operation
- **Pending register**
  - Sampled every `clk` with priority right > left > up > down.
  - Any asserted button loads `pend_dir` and sets `pend_v`.
  - A press in the same cycle as a pending-clear wins: `pend_v` stays 1 with the new direction.
- **FSM states:** IDLE, QRY_P, QRY_C.
- **IDLE on `tick`**
  - If `pend_v` and `pend_dir` != `dir` (or `moving`=0): go to QRY_P.
  - Else if `moving`: go to QRY_C.
  - Else stay in IDLE.
- **Ticks outside IDLE** are ignored (dropped, not queued).
- **QRY_P / QRY_C query**
  - Drive `probe_req`=1 and `probe_x/y` = next position for `pend_dir` (QRY_P) or `dir` (QRY_C).
  - Hold both until a cycle with `probe_ack`=1.
- **QRY_P, not blocked:** commit the position, `dir`<=`pend_dir`, `moving`<=1, `pend_v`<=0, go to IDLE.
- **QRY_P, blocked:** go to QRY_C if `moving`, else IDLE. Pending is kept for the next tick.
- **QRY_C, not blocked:** commit the position, go to IDLE.
- **QRY_C, blocked:** `moving`<=0, position unchanged, go to IDLE.
- **Commit with L:** sets `face_left`=1. Commit with R clears it. U/D leave it unchanged.
- **Next position** (W-bit, no underflow)
  - R: `x+STEP > X_MAX` ? `X_MIN` : `x+STEP`.
  - L: `x < X_MIN+STEP` ? `X_MAX` : `x-STEP`.
  - U and D: same rules on y with `Y_MIN`/`Y_MAX`.
- **Reversal** (pending is the opposite of `dir`) is an ordinary pending request.
- **`spr_fill`:** `hCount` in [`pos_x`+1, `pos_x`+`SPR_W`] and `vCount` in [`pos_y`, `pos_y`+`SPR_H`-1].
- **`spr_row`:** `vCount`-`pos_y`.
- **`spr_col`:** c=`hCount`-`pos_x`-1; `spr_col` = `face_left` ? c : `SPR_W`-1-c.

## Timing
- **Reset values:**
  - `pos_x`=`START_X`, `pos_y`=`START_Y`.
  - `dir`=R, `moving`=0, `face_left`=0.
  - `probe_req`=0, `probe_x/y`=0.
  - `pend_v`=0, FSM in IDLE.
- **Probe launch:** `probe_req` rises the cycle after `tick`.
- **Latency:** minimum tick-to-position update is 2 cycles (ack in the first probe cycle).
- **Worst case:** two probes (P then C).
- **Ack timing:** ack in the same cycle the request is first driven is legal. An ack while `probe_req`=0 is ignored.
- **Reset mid-query:** `probe_req` drops asynchronously and no commit happens.
- **Pixel outputs:** `spr_fill`, `spr_row` and `spr_col` are combinational from the registered position.

## Structure
- Package `pm_motion_pkg`: `dir_t` (R/L/U/D) and `mstate_t` (IDLE/QRY_P/QRY_C).
- Sub-module `sprite_next_pos`: combinational step-and-wrap, parametrised by bounds and `STEP`.
  - Instantiated once; its direction input is muxed from `pend_dir`/`dir`.

## Test plan
- **Reset default:** reset, then `tick` with no buttons → no `probe_req`; pos=(450,250), `moving`=0.
- **Start moving:** `right` pulse, `tick`, ack unblocked → pos=(452,250), `dir`=R, `face_left`=0.
  - A further `tick` with no button → QRY_C probe at (454,250).
- **Buffered turn:** moving R, press `up`, first ack blocked → QRY_C follows at x+2 and commits.
  - `pend_v` stays set.
  - Next tick's QRY_P unblocked → y-=2, `dir`=U.
- **Wrap:** at x=800 moving R, tick → `probe_x`=150, commit to 150.
  - Moving L at x=151, tick → `probe_x`=800.
- **Wall stop:** QRY_C blocked → `moving`=0, position unchanged.
  - A tick while a 5-cycle-delayed ack is outstanding is ignored; only one commit occurs.
- **Reset mid-query:** `rst` while `probe_req`=1 and ack pending → `probe_req`=0 immediately, pos=(450,250).
